// File: rtl/hyperbus_ctrl.sv
// HyperBus primary controller: multi-CS, counted linear/wrapped bursts, masked and
// back-pressured writes, zero-latency register writes and read timeout recovery.
module hyperbus_ctrl #(
    parameter int WIDTH         = 8,
    parameter int NUM_CS        = 2,
    parameter int TACC_COUNT    = 6,
    parameter int FIXED_LATENCY = 0,
    parameter int RESET_COUNT   = 4,
    parameter int BURST_BITS    = 8,
    parameter int TIMEOUT_COUNT = 32,
    parameter int CSHI_COUNT    = 2,
    localparam int CSW          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk90,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_reg,
    input  logic                  cmd_wrap,
    input  logic [CSW-1:0]        cmd_cs,
    input  logic [31:0]           cmd_adr,
    input  logic [BURST_BITS-1:0] cmd_len,
    input  logic [2*WIDTH-1:0]    wr_data,
    input  logic [1:0]            wr_mask,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [2*WIDTH-1:0]    rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  phy_rstn,
    output logic [NUM_CS-1:0]     phy_csn,
    output logic                  phy_ck_en,
    output logic [2*WIDTH-1:0]    phy_dq_o,
    output logic                  phy_dq_oe,
    input  logic [2*WIDTH-1:0]    phy_dq_i,
    output logic [1:0]            phy_rwds_o,
    output logic                  phy_rwds_oe,
    input  logic [1:0]            phy_rwds_i
);

    localparam int DW     = 2 * WIDTH;
    localparam int LAT_W  = $clog2(2 * TACC_COUNT + 1);
    localparam int RST_W  = $clog2(RESET_COUNT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_COUNT + 1);
    localparam int CSHI_W = $clog2(CSHI_COUNT + 1);

    typedef enum logic [2:0] {
        RESET,
        IDLE,
        CMD,
        LATENCY,
        WRITE,
        READ,
        CSHI
    } state_t;

    state_t                state;
    logic [1:0]            cmd_cnt;
    logic [47:0]           ca;
    logic                  is_write;
    logic                  is_reg;
    logic [BURST_BITS-1:0] word_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [RST_W-1:0]      rst_cnt;
    logic [CSHI_W-1:0]     cshi_cnt;
    logic                  closing;
    logic                  timed_out;

    logic [47:0]           ca_next;
    logic [NUM_CS-1:0]     cs_sel;
    logic                  lat_long;

    assign ca_next  = {~cmd_write, cmd_reg, ~cmd_wrap, cmd_adr[31:3], 13'd0, cmd_adr[2:0]};
    assign lat_long = (FIXED_LATENCY != 0) || (phy_rwds_i == 2'b11);

    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cmd_cs == CSW'(i)) begin
                cs_sel[i] = 1'b0;
            end
        end
    end

    // Single registered FSM; every pad-side and user-side output is a flop.
    // closing marks the first CSHI cycle, where the bus is released and done fires.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state       <= RESET;
            cmd_cnt     <= '0;
            ca          <= '0;
            is_write    <= 1'b0;
            is_reg      <= 1'b0;
            word_cnt    <= '0;
            lat_cnt     <= '0;
            tmo_cnt     <= '0;
            rst_cnt     <= '0;
            cshi_cnt    <= '0;
            closing     <= 1'b0;
            timed_out   <= 1'b0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
            phy_rstn    <= 1'b0;
            phy_csn     <= '1;
            phy_ck_en   <= 1'b0;
            phy_dq_o    <= '0;
            phy_dq_oe   <= 1'b0;
            phy_rwds_o  <= '0;
            phy_rwds_oe <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state)
                RESET: begin
                    if (rst_cnt == RST_W'(RESET_COUNT - 1)) begin
                        phy_rstn  <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        is_write  <= cmd_write;
                        is_reg    <= cmd_reg;
                        word_cnt  <= (cmd_write && cmd_reg) ? '0 : cmd_len;
                        ca        <= {ca_next[31:0], 16'd0};
                        cmd_cnt   <= '0;
                        timed_out <= 1'b0;
                        phy_csn   <= cs_sel;
                        phy_ck_en <= 1'b1;
                        phy_dq_oe <= 1'b1;
                        phy_dq_o  <= DW'(ca_next[47:32]);
                        state     <= CMD;
                    end
                end

                CMD: begin
                    if (cmd_cnt == 2'd2) begin
                        phy_dq_oe   <= 1'b0;
                        phy_dq_o    <= '0;
                        phy_rwds_oe <= 1'b0;
                        lat_cnt     <= lat_long ? LAT_W'(2 * TACC_COUNT - 1)
                                                : LAT_W'(TACC_COUNT - 1);
                        if (is_write && is_reg) begin
                            wr_ready  <= 1'b1;
                            phy_ck_en <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            state <= LATENCY;
                        end
                    end else begin
                        cmd_cnt  <= cmd_cnt + 1'b1;
                        phy_dq_o <= DW'(ca[47:32]);
                        ca       <= {ca[31:0], 16'd0};
                    end
                end

                LATENCY: begin
                    if (lat_cnt == '0) begin
                        if (is_write) begin
                            wr_ready  <= 1'b1;
                            phy_ck_en <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            tmo_cnt <= TMO_W'(TIMEOUT_COUNT);
                            state   <= READ;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                // Clock only runs on cycles that carry a word, so a stall costs nothing.
                WRITE: begin
                    if (wr_valid && wr_ready) begin
                        phy_ck_en   <= 1'b1;
                        phy_dq_oe   <= 1'b1;
                        phy_dq_o    <= wr_data;
                        phy_rwds_oe <= ~is_reg;
                        phy_rwds_o  <= ~wr_mask;
                        if (word_cnt == '0) begin
                            wr_ready <= 1'b0;
                            closing  <= 1'b1;
                            state    <= CSHI;
                        end else begin
                            word_cnt <= word_cnt - 1'b1;
                        end
                    end else begin
                        phy_ck_en <= 1'b0;
                    end
                end

                READ: begin
                    if (phy_rwds_i == 2'b01) begin
                        rd_data  <= phy_dq_i;
                        rd_valid <= 1'b1;
                        tmo_cnt  <= TMO_W'(TIMEOUT_COUNT);
                        if (word_cnt == '0) begin
                            closing <= 1'b1;
                            state   <= CSHI;
                        end else begin
                            word_cnt <= word_cnt - 1'b1;
                        end
                    end else if (tmo_cnt == TMO_W'(1)) begin
                        timed_out <= 1'b1;
                        closing   <= 1'b1;
                        state     <= CSHI;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end

                CSHI: begin
                    if (closing) begin
                        closing     <= 1'b0;
                        phy_csn     <= '1;
                        phy_ck_en   <= 1'b0;
                        phy_dq_oe   <= 1'b0;
                        phy_rwds_oe <= 1'b0;
                        phy_dq_o    <= '0;
                        phy_rwds_o  <= '0;
                        done        <= 1'b1;
                        err         <= timed_out;
                        cshi_cnt    <= CSHI_W'(CSHI_COUNT - 1);
                    end else if (cshi_cnt <= CSHI_W'(1)) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cshi_cnt <= cshi_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Randomized self-checking bench for hyperbus_ctrl; a transaction-level model
// derives expected pad and user-port activity from the command and device behaviour.
module tb_hyperbus_ctrl;

    localparam int TACC    = 6;
    localparam int RSTC    = 4;
    localparam int TIMEOUT = 32;

    logic        clk90 = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_reg = 1'b0;
    logic        cmd_wrap = 1'b0;
    logic [0:0]  cmd_cs = '0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_mask = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic        phy_rstn;
    logic [1:0]  phy_csn;
    logic        phy_ck_en;
    logic [15:0] phy_dq_o;
    logic        phy_dq_oe;
    logic [15:0] phy_dq_i = '0;
    logic [1:0]  phy_rwds_o;
    logic        phy_rwds_oe;
    logic [1:0]  phy_rwds_i = '0;

    int checks = 0;
    int failures = 0;

    hyperbus_ctrl dut (
        .clk90(clk90), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_reg(cmd_reg), .cmd_wrap(cmd_wrap), .cmd_cs(cmd_cs),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
        .phy_rstn(phy_rstn), .phy_csn(phy_csn), .phy_ck_en(phy_ck_en),
        .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_dq_i(phy_dq_i),
        .phy_rwds_o(phy_rwds_o), .phy_rwds_oe(phy_rwds_oe), .phy_rwds_i(phy_rwds_i)
    );

    always #5 clk90 = ~clk90;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk90);
        @(negedge clk90);
    endtask

    task automatic doReset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        phy_rwds_i = 2'b00;
        phy_dq_i = '0;
        step();
        checkOutput("reset phy_rstn", phy_rstn, 0);
        checkOutput("reset phy_csn", phy_csn, 2'b11);
        checkOutput("reset busy", busy, 1);
        checkOutput("reset cmd_ready", cmd_ready, 0);
        checkOutput("reset wr_ready", wr_ready, 0);
        checkOutput("reset dq_oe", phy_dq_oe, 0);
        checkOutput("reset rwds_oe", phy_rwds_oe, 0);
        checkOutput("reset ck_en", phy_ck_en, 0);
        checkOutput("reset dq_o", phy_dq_o, 0);
        checkOutput("reset rwds_o", phy_rwds_o, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset rd_valid", rd_valid, 0);
        rst = 1'b0;
        for (int i = 1; i <= RSTC; i++) begin
            step();
            checkOutput("rstn sequence", phy_rstn, (i == RSTC));
            checkOutput("ready after reset", cmd_ready, (i == RSTC));
            checkOutput("no done in reset", done, 0);
        end
        checkOutput("idle busy", busy, 0);
    endtask

    // mode: 0 random handshakes, 1 three-cycle write stall, 2 no read strobes, 3 strobe every cycle
    task automatic applyStimulus(input logic w, input logic r, input logic wrap,
                                 input logic [0:0] cs, input logic [31:0] adr,
                                 input logic [7:0] len, input logic [1:0] rwds_cmd,
                                 input int mode);
        logic [47:0] ca;
        logic [1:0]  exp_csn;
        logic [15:0] data;
        logic [15:0] last_data;
        logic [1:0]  mask;
        logic [1:0]  nmask;
        logic        reg_wr;
        logic        valid;
        logic        strobe;
        logic        timed;
        int          lat;
        int          words;
        int          left;
        int          sent;
        int          stalls;
        int          quiet;
        int          budget;

        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        checkOutput("cmd_ready before accept", cmd_ready, 1);

        ca = {~w, r, ~wrap, adr[31:3], 13'd0, adr[2:0]};
        exp_csn = 2'b11;
        exp_csn[cs] = 1'b0;
        reg_wr = w && r;
        lat = reg_wr ? 0 : ((rwds_cmd == 2'b11) ? 2 * TACC : TACC);
        words = reg_wr ? 1 : int'(len) + 1;

        cmd_write = w;
        cmd_reg = r;
        cmd_wrap = wrap;
        cmd_cs = cs;
        cmd_adr = adr;
        cmd_len = len;
        cmd_valid = 1'b1;
        phy_rwds_i = rwds_cmd;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            checkOutput($sformatf("ca word %0d", k), phy_dq_o, ca[47-16*k -: 16]);
            checkOutput("cmd dq_oe", phy_dq_oe, 1);
            checkOutput("cmd csn", phy_csn, exp_csn);
        end
        checkOutput("cmd busy", busy, 1);
        step();
        phy_rwds_i = 2'b00;

        for (int i = 0; i < lat; i++) begin
            if (i > 0) step();
            checkOutput("latency dq_oe", phy_dq_oe, 0);
            checkOutput("latency csn", phy_csn, exp_csn);
            if (w) checkOutput("latency wr_ready", wr_ready, 0);
        end
        if (lat > 0) step();

        if (w) begin
            checkOutput("write entry wr_ready", wr_ready, 1);
            left = words;
            sent = 0;
            stalls = 0;
            last_data = '0;
            while (left > 0) begin
                if (mode == 1) valid = !(sent == 1 && stalls < 3);
                else valid = (stalls >= 3) || ($urandom_range(0, 3) != 0);
                data = 16'($urandom);
                mask = 2'($urandom_range(0, 3));
                nmask = ~mask;
                wr_valid = valid;
                wr_data = data;
                wr_mask = mask;
                step();
                if (valid) begin
                    checkOutput("write dq_o", phy_dq_o, data);
                    checkOutput("write dq_oe", phy_dq_oe, 1);
                    checkOutput("write rwds_o", phy_rwds_o, nmask);
                    checkOutput("write rwds_oe", phy_rwds_oe, !reg_wr);
                    checkOutput("write ck_en", phy_ck_en, 1);
                    left--;
                    sent++;
                    stalls = 0;
                    last_data = data;
                    checkOutput("wr_ready after word", wr_ready, (left > 0));
                end else begin
                    checkOutput("stall ck_en", phy_ck_en, 0);
                    if (sent > 0) checkOutput("stall dq_o hold", phy_dq_o, last_data);
                    stalls++;
                end
            end
            wr_valid = 1'b0;
            step();
            checkOutput("write done", done, 1);
            checkOutput("write err", err, 0);
        end else begin
            left = words;
            quiet = 0;
            timed = 1'b0;
            while (left > 0 && !timed) begin
                if (mode == 2) strobe = 1'b0;
                else if (mode == 3) strobe = 1'b1;
                else strobe = ($urandom_range(0, 2) != 0);
                data = 16'($urandom);
                phy_dq_i = data;
                if (strobe) phy_rwds_i = 2'b01;
                else begin
                    case ($urandom_range(0, 2))
                        0: phy_rwds_i = 2'b00;
                        1: phy_rwds_i = 2'b10;
                        default: phy_rwds_i = 2'b11;
                    endcase
                end
                step();
                checkOutput("rd_valid", rd_valid, strobe);
                if (strobe) begin
                    checkOutput("rd_data", rd_data, data);
                    left--;
                    quiet = 0;
                end else begin
                    quiet++;
                    if (quiet == TIMEOUT) timed = 1'b1;
                end
            end
            phy_rwds_i = 2'b00;
            step();
            checkOutput("read done", done, 1);
            checkOutput("read err", err, timed);
            checkOutput("read no extra rd_valid", rd_valid, 0);
        end

        checkOutput("cshi csn", phy_csn, 2'b11);
        checkOutput("cshi dq_oe", phy_dq_oe, 0);
        checkOutput("cshi ck_en", phy_ck_en, 0);
        checkOutput("cshi cmd_ready", cmd_ready, 0);
        step();
        checkOutput("done one pulse", done, 0);
        checkOutput("cshi csn held", phy_csn, 2'b11);
        checkOutput("idle cmd_ready", cmd_ready, 1);
        checkOutput("idle busy", busy, 0);
    endtask

    initial begin
        logic [1:0] rw;
        doReset();

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0123, 8'd3, 2'b00, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 8'd1, 2'b11, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h00AB_CDEF, 8'd5, 2'b00, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 8'd7, 2'b00, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 8'd3, 2'b00, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 8'd255, 2'b11, 3);

        for (int t = 0; t < 10; t++) begin
            rw = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, 8'($urandom_range(0, 7)), rw, 0);
        end

        cmd_write = 1'b0;
        cmd_reg = 1'b0;
        cmd_cs = 1'b0;
        cmd_len = 8'd3;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset csn", phy_csn, 2'b11);
        checkOutput("midreset dq_oe", phy_dq_oe, 0);
        checkOutput("midreset ck_en", phy_ck_en, 0);
        checkOutput("midreset phy_rstn", phy_rstn, 0);
        checkOutput("midreset done", done, 0);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 8'd2, 2'b00, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_ctrl.md
# hyperbus_ctrl

Parametrised HyperBus primary controller, the successor to the single-device controller. It adds multiple chip selects, counted linear/wrapped bursts, write byte masks, a back-pressured write path, zero-latency register writes, and read timeout with recovery. The block sits between a user command port and a DDR PHY (the `ioddr` pair plus clock gate). It runs entirely in the clk90 domain, and all pad-side signals are registered half-rate DDR words.

## Interface
- WIDTH, 8, DQ pad width; each user word is 2*WIDTH bits.
- NUM_CS, 2, number of chip selects; CSW = max(1, clog2(NUM_CS)).
- TACC_COUNT, 6, 1x initial latency in clk90 cycles.
- FIXED_LATENCY, 0, when 1, always use 2x latency and ignore RWDS during CMD.
- RESET_COUNT, 4, cycles phy_rstn is held low after reset.
- BURST_BITS, 8, width of cmd_len.
- TIMEOUT_COUNT, 32, cycles without a read strobe before the read is aborted.
- CSHI_COUNT, 2, minimum idle cycles with all CS# high between transactions.
- clk90  in  1  controller clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_reg  in  1  register space.
- cmd_wrap  in  1  1 = wrapped burst, 0 = linear.
- cmd_cs  in  CSW  target device.
- cmd_adr  in  32  word address.
- cmd_len  in  BURST_BITS  burst length in words, minus 1.
- wr_data  in  2*WIDTH  write word; the upper byte goes out first.
- wr_mask  in  2  byte enables; bit1 = upper byte.
- wr_valid  in  1  write word available.
- wr_ready  out  1  word consumed when wr_valid && wr_ready.
- rd_data  out  2*WIDTH  read word.
- rd_valid  out  1  rd_data valid, one-cycle pulse per word.
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  valid with done; 1 = read timeout.
- busy  out  1  state != IDLE.
- phy_rstn  out  1  device reset.
- phy_csn  out  NUM_CS  chip selects, active low.
- phy_ck_en  out  1  HyperBus clock enable.
- phy_dq_o  out  2*WIDTH  DQ DDR word.
- phy_dq_oe  out  1  DQ output enable.
- phy_dq_i  in  2*WIDTH  captured DQ word.
- phy_rwds_o  out  2  RWDS DDR pair.
- phy_rwds_oe  out  1  RWDS output enable.
- phy_rwds_i  in  2  captured RWDS pair.

## Operation
- States: RESET, IDLE, CMD, LATENCY, WRITE, READ, CSHI.
- Reset values:
  - state = RESET.
  - phy_rstn = 0 and phy_csn = all 1s.
  - phy_ck_en, phy_dq_oe and phy_rwds_oe = 0.
  - phy_dq_o and phy_rwds_o = 0.
  - cmd_ready, wr_ready, rd_valid, done and err = 0.
  - busy = 1.
- RESET: hold phy_rstn = 0 for RESET_COUNT cycles, then go to IDLE.
- IDLE: cmd_ready = 1. On accept, latch the command and build the 48-bit CA word:
  - ca[47] = ~cmd_write and ca[46] = cmd_reg.
  - ca[45] = ~cmd_wrap.
  - ca[44:16] = adr[31:3], ca[15:3] = 0, ca[2:0] = adr[2:0].
  - Then go to CMD.
- CMD: 3 cycles.
  - Outputs: phy_csn[cmd_cs] = 0, phy_dq_oe = 1, phy_ck_en = 1, phy_dq_o = ca[47:32]; ca shifts left by 16 each cycle.
  - The RWDS value sampled in the third cycle selects the latency: phy_rwds_i == 2'b11 (or FIXED_LATENCY) gives 2*TACC_COUNT, otherwise TACC_COUNT.
  - Register write: go directly to WRITE with length forced to 1 word and phy_rwds_oe kept at 0.
  - Otherwise go to LATENCY.
- LATENCY: phy_dq_oe = 0 and phy_rwds_oe = 0; count down the selected latency, then go to WRITE or READ.
- WRITE:
  - wr_ready = 1.
  - On wr_valid: phy_dq_oe = 1, phy_dq_o = wr_data, phy_rwds_oe = 1 (except register writes), phy_rwds_o = ~wr_mask. The word counter decrements.
  - If wr_valid = 0: phy_ck_en = 0 (clock paused) and outputs hold; no word is counted.
  - After the last word, go to CSHI.
- READ:
  - On phy_rwds_i == 2'b01: rd_data = phy_dq_i, rd_valid = 1, the word counter decrements, and the timeout counter reloads.
  - Any other RWDS value means no word that cycle.
  - After the last word, go to CSHI with err = 0.
  - If the timeout counter reaches 0, go to CSHI with err = 1; remaining words are dropped.
- CSHI:
  - Outputs: phy_csn all 1s, phy_ck_en = 0, both output enables 0.
  - done (and err) pulse in the first CSHI cycle.
  - Stay for CSHI_COUNT cycles, then go to IDLE.

## Timing
- All outputs are registered. Each state's outputs appear in the cycle after the state is entered.
- Command to first CA word on phy_dq_o: 1 cycle after accept.
- Read data: rd_valid is asserted 1 cycle after the strobe is seen on phy_rwds_i.
- Write with no stalls: total time = 3 (CMD) + latency + len+1 cycles.
- cmd_valid during RESET, busy or CSHI is ignored; no queuing.
- The write counter and the read counter each count len+1 words; len = 2^BURST_BITS-1 gives 2^BURST_BITS words with no overflow.
- rst mid-transaction: outputs take their reset values immediately (CS# high, OEs off), the device reset pulse is re-issued, and no done is produced.

## Test plan
- Reset: release rst -> phy_rstn low for 4 cycles, then IDLE, cmd_ready = 1, phy_csn = 2'b11.
- 1x read: cmd_adr = 0x000123, len = 3, cs = 1, RWDS = 00 during CMD -> phy_dq_o words 0xA000, 0x0024, 0x0003. Then 6 latency cycles, then 4 rd_valid pulses on 01 strobes, then done = 1 with err = 0.
- 2x latency write: RWDS = 11 during CMD, len = 1, wr_mask = 2'b10 -> 12 latency cycles, then phy_rwds_o = 2'b01 on the first word, then done.
- Write stall: drop wr_valid for 3 cycles mid-burst -> phy_ck_en = 0 for those 3 cycles and the word count is unchanged.
- Register write: cmd_reg = 1, cmd_write = 1 -> WRITE immediately after CMD, exactly 1 word, phy_rwds_oe = 0.
- Timeout: read with no strobes -> after 32 cycles done = 1, err = 1, then CSHI for 2 cycles, then IDLE.
